// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store front end placed directly upstream of datamem.
//   Aligned requests pass straight through in the same cycle. Misaligned
//   requests are broken into single-byte transfers, one per cycle, and the
//   pipeline is stalled until the last byte goes out. Load data is masked to
//   the access size and then zero- or sign-extended. A request with an illegal
//   size, or one that would run past the end of datamem, is never sent to
//   memory; it is flagged on fault instead.
//
//   Optional feature macro: MAU_PERF_CNT_EN
//     defined   -> perf_split_count counts misaligned requests entering SPLIT
//                  (saturates at all-ones, cleared by reset)
//     undefined -> perf_split_count is tied to 0 and no counter flops exist
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/write/signed/addr/wdata/size
//                         MEM-stage request; must hold stable while stall=1
//   stall                 hold the MEM stage
//   resp_valid            access finishes this cycle
//   resp_rdata            extended load data (0 for stores and faults)
//   fault                 request rejected (size or bounds); no memory access
//   mem_address, mem_write_enable, mem_read_enable, mem_write_data,
//   mem_xfer_size         datamem request side
//   mem_read_data         datamem combinational read data
//   perf_split_count      count of split accesses started
//
// States
//   state | meaning
//   IDLE  | no split in progress; new requests are classified here
//   SPLIT | byte-serial access in progress, byte index in k_q
module mem_access_unit #(
  parameter int DATA_MEM_SIZE = 1024,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic                 req_signed,
  input  logic [63:0]          req_addr,
  input  logic [63:0]          req_wdata,
  input  logic [3:0]           req_size,
  output logic                 stall,
  output logic                 resp_valid,
  output logic [63:0]          resp_rdata,
  output logic                 fault,
  output logic [63:0]          mem_address,
  output logic                 mem_write_enable,
  output logic                 mem_read_enable,
  output logic [63:0]          mem_write_data,
  output logic [3:0]           mem_xfer_size,
  input  logic [63:0]          mem_read_data,
  output logic [CNT_WIDTH-1:0] perf_split_count
);

  typedef enum logic {IDLE, SPLIT} state_t;

  localparam logic [64:0] MEM_LIMIT = 65'(DATA_MEM_SIZE);

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d, k_cur;
  logic [63:0] buf_q, buf_d;

  logic        size_ok;
  logic        in_bounds;
  logic        aligned;
  logic [64:0] end_addr;
  logic [3:0]  size_m1;
  logic [2:0]  last_k;
  logic [7:0]  wdata_byte;
  logic [63:0] assembled;

  // Mask to the access size, then extend. Size 8 passes through unchanged.
  function automatic logic [63:0] fmt_load(input logic [63:0] raw,
                                           input logic [3:0]  size,
                                           input logic        sgn);
    logic [63:0] r;
    case (size)
      4'd1:    r = sgn ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
      4'd2:    r = sgn ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
      4'd4:    r = sgn ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  always_comb begin
    case (req_size)
      4'd1, 4'd2, 4'd4, 4'd8: size_ok = 1'b1;
      default:                size_ok = 1'b0;
    endcase
  end

  // 65-bit sum so an address near 2^64 carries out and faults.
  assign end_addr  = {1'b0, req_addr} + {61'd0, req_size};
  assign in_bounds = (end_addr <= MEM_LIMIT);
  assign size_m1   = req_size - 4'd1;
  assign aligned   = ((req_addr[3:0] & size_m1) == 4'd0);
  assign last_k    = size_m1[2:0];

  // Byte index is 0 on the first split cycle, which happens in IDLE.
  assign k_cur      = (state_q == SPLIT) ? k_q : 3'd0;
  assign wdata_byte = req_wdata[{k_cur, 3'b000} +: 8];

  // Buffer with the current byte merged in from memory.
  always_comb begin
    assembled = buf_q;
    assembled[{k_cur, 3'b000} +: 8] = mem_read_data[7:0];
  end

  always_comb begin
    state_d          = state_q;
    k_d              = k_q;
    buf_d            = buf_q;
    stall            = 1'b0;
    resp_valid       = 1'b0;
    resp_rdata       = 64'd0;
    fault            = 1'b0;
    mem_address      = 64'd0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_data   = 64'd0;
    mem_xfer_size    = 4'd0;

    if (reset) begin
      state_d = IDLE;
      k_d     = 3'd0;
      buf_d   = 64'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (!size_ok || !in_bounds) begin
              fault      = 1'b1;
              resp_valid = 1'b1;
            end else if (aligned) begin
              mem_address      = req_addr;
              mem_write_enable = req_write;
              mem_read_enable  = ~req_write;
              mem_write_data   = req_wdata;
              mem_xfer_size    = req_size;
              resp_valid       = 1'b1;
              resp_rdata       = req_write ? 64'd0
                                           : fmt_load(mem_read_data, req_size, req_signed);
            end else begin
              mem_address      = req_addr;
              mem_write_enable = req_write;
              mem_read_enable  = ~req_write;
              mem_write_data   = {56'd0, wdata_byte};
              mem_xfer_size    = 4'd1;
              stall            = 1'b1;
              buf_d            = req_write ? 64'd0 : assembled;
              k_d              = 3'd1;
              state_d          = SPLIT;
            end
          end
        end

        SPLIT: begin
          mem_address      = req_addr + {61'd0, k_q};
          mem_write_enable = req_write;
          mem_read_enable  = ~req_write;
          mem_write_data   = {56'd0, wdata_byte};
          mem_xfer_size    = 4'd1;
          if (k_q == last_k) begin
            resp_valid = 1'b1;
            resp_rdata = req_write ? 64'd0
                                   : fmt_load(assembled, req_size, req_signed);
            state_d    = IDLE;
            k_d        = 3'd0;
            buf_d      = 64'd0;
          end else begin
            stall = 1'b1;
            buf_d = req_write ? buf_q : assembled;
            k_d   = k_q + 3'd1;
          end
        end

        default: begin
          state_d = IDLE;
          k_d     = 3'd0;
          buf_d   = 64'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      buf_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
    end
  end

`ifdef MAU_PERF_CNT_EN
  logic                 split_start;
  logic [CNT_WIDTH-1:0] perf_q;

  assign split_start = (state_q == IDLE) && (state_d == SPLIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (split_start && !(&perf_q)) begin
      perf_q <= perf_q + 1'b1;
    end
  end

  assign perf_split_count = perf_q;
`else
  assign perf_split_count = '0;
`endif

endmodule
